// File: rtl/axi_lite_reg_slave_if.sv
// AXI-lite bus bundle between an AXI master and the register-file responder.
// Signal names follow the bus channel naming (AW/W/B/AR/R). The master drives
// addresses, data, valids and response readies; the slave drives the rest.
interface axi_lite_reg_slave_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    // Write address channel
    logic [ADDR_WIDTH-1:0] AW_addr;
    logic                  AW_valid;
    logic                  AW_ready;

    // Write data channel
    logic [DATA_WIDTH-1:0] W_data;
    logic                  W_valid;
    logic                  W_ready;

    // Write response channel (1-bit response: 0 OKAY, 1 SLVERR)
    logic                  B_resp;
    logic                  B_valid;
    logic                  B_ready;

    // Read address channel
    logic [ADDR_WIDTH-1:0] AR_addr;
    logic                  AR_valid;
    logic                  AR_ready;

    // Read data channel (1-bit response: 0 OKAY, 1 SLVERR)
    logic [DATA_WIDTH-1:0] R_data;
    logic                  R_resp;
    logic                  R_valid;
    logic                  R_ready;

    modport master (
        output AW_addr, AW_valid,
        input  AW_ready,
        output W_data, W_valid,
        input  W_ready,
        input  B_resp, B_valid,
        output B_ready,
        output AR_addr, AR_valid,
        input  AR_ready,
        input  R_data, R_resp, R_valid,
        output R_ready
    );

    modport slave (
        input  AW_addr, AW_valid,
        output AW_ready,
        input  W_data, W_valid,
        output W_ready,
        output B_resp, B_valid,
        input  B_ready,
        input  AR_addr, AR_valid,
        output AR_ready,
        output R_data, R_resp, R_valid,
        input  R_ready
    );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI-lite register-file responder.
// Terminates AW/W/B and AR/R into NUM_REGS registers of DATA_WIDTH bits.
// The write and read paths are independent FSMs and may both be busy in the
// same cycle. Addresses at or above NUM_REGS get SLVERR: writes are dropped and
// reads return zero. A read and a write to the same register on the same edge
// return the pre-write value, because read data is taken from the register
// array before the write lands.
// All bus outputs, including the readies, come straight from flops; each ready
// is loaded with the value it must have in the following cycle.
module axi_lite_reg_slave #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 16
) (
    input  logic                 A_clk,
    input  logic                 A_reset,
    axi_lite_reg_slave_if.slave  bus
);

    // Register index width; at least one bit so the slice below stays legal.
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    // NUM_REGS widened by one bit so the range compare cannot overflow.
    localparam logic [ADDR_WIDTH:0] NUM_REGS_EXT = (ADDR_WIDTH + 1)'(NUM_REGS);

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Full-width address compare: no aliasing or wrap above NUM_REGS.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} < NUM_REGS_EXT);
    endfunction

    // Register bank
    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];

    // Write path state
    wr_state_t             wr_state_r;
    logic                  aw_held_r;
    logic                  w_held_r;
    logic [ADDR_WIDTH-1:0] aw_addr_r;
    logic [DATA_WIDTH-1:0] w_data_r;
    logic                  aw_ready_r;
    logic                  w_ready_r;
    logic                  b_valid_r;
    logic                  b_resp_r;

    // Read path state
    rd_state_t             rd_state_r;
    logic                  ar_ready_r;
    logic                  r_valid_r;
    logic                  r_resp_r;
    logic [DATA_WIDTH-1:0] r_data_r;

    // Write-side combinational decode
    logic                  aw_hs_s;
    logic                  w_hs_s;
    logic                  commit_s;
    logic [ADDR_WIDTH-1:0] commit_addr_s;
    logic [DATA_WIDTH-1:0] commit_data_s;
    logic                  wr_en_s;

    // Read-side combinational decode
    logic                  ar_hs_s;
    logic                  rd_hit_s;
    logic [DATA_WIDTH-1:0] rd_data_s;

    // Handshakes, commit detection and the address/data used by a commit.
    always_comb begin
        aw_hs_s       = bus.AW_valid & aw_ready_r;
        w_hs_s        = bus.W_valid & w_ready_r;
        commit_addr_s = aw_addr_r;
        commit_data_s = w_data_r;
        commit_s      = 1'b0;
        wr_en_s       = 1'b0;
        if (aw_hs_s) begin
            commit_addr_s = bus.AW_addr;
        end else begin
            commit_addr_s = aw_addr_r;
        end
        if (w_hs_s) begin
            commit_data_s = bus.W_data;
        end else begin
            commit_data_s = w_data_r;
        end
        if ((wr_state_r == W_IDLE) && (aw_held_r || aw_hs_s) && (w_held_r || w_hs_s)) begin
            commit_s = 1'b1;
            wr_en_s  = in_range(commit_addr_s);
        end else begin
            commit_s = 1'b0;
            wr_en_s  = 1'b0;
        end
    end

    // Read address handshake and read-data selection from the current bank.
    always_comb begin
        ar_hs_s   = bus.AR_valid & ar_ready_r;
        rd_hit_s  = in_range(bus.AR_addr);
        rd_data_s = {DATA_WIDTH{1'b0}};
        if (rd_hit_s) begin
            rd_data_s = regs_r[bus.AR_addr[IDX_W-1:0]];
        end else begin
            rd_data_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Register bank: cleared on reset, written only by an in-range commit.
    always_ff @(posedge A_clk or negedge A_reset) begin
        if (!A_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[commit_addr_s[IDX_W-1:0]] <= commit_data_s;
        end
    end

    // Write FSM: collect AW and W in any order, commit, then hold B until accepted.
    always_ff @(posedge A_clk or negedge A_reset) begin
        if (!A_reset) begin
            wr_state_r <= W_IDLE;
            aw_held_r  <= 1'b0;
            w_held_r   <= 1'b0;
            aw_addr_r  <= {ADDR_WIDTH{1'b0}};
            w_data_r   <= {DATA_WIDTH{1'b0}};
            aw_ready_r <= 1'b0;
            w_ready_r  <= 1'b0;
            b_valid_r  <= 1'b0;
            b_resp_r   <= 1'b0;
        end else begin
            case (wr_state_r)
                W_IDLE: begin
                    if (commit_s) begin
                        b_valid_r  <= 1'b1;
                        b_resp_r   <= ~in_range(commit_addr_s);
                        aw_held_r  <= 1'b0;
                        w_held_r   <= 1'b0;
                        aw_ready_r <= 1'b0;
                        w_ready_r  <= 1'b0;
                        wr_state_r <= W_RESP;
                    end else begin
                        if (aw_hs_s) begin
                            aw_held_r  <= 1'b1;
                            aw_addr_r  <= bus.AW_addr;
                            aw_ready_r <= 1'b0;
                        end else begin
                            aw_ready_r <= ~aw_held_r;
                        end
                        if (w_hs_s) begin
                            w_held_r  <= 1'b1;
                            w_data_r  <= bus.W_data;
                            w_ready_r <= 1'b0;
                        end else begin
                            w_ready_r <= ~w_held_r;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.B_ready) begin
                        b_valid_r  <= 1'b0;
                        aw_ready_r <= 1'b1;
                        w_ready_r  <= 1'b1;
                        wr_state_r <= W_IDLE;
                    end
                end
                default: begin
                    wr_state_r <= W_IDLE;
                    aw_held_r  <= 1'b0;
                    w_held_r   <= 1'b0;
                    aw_ready_r <= 1'b0;
                    w_ready_r  <= 1'b0;
                    b_valid_r  <= 1'b0;
                    b_resp_r   <= 1'b0;
                end
            endcase
        end
    end

    // Read FSM: sample the bank on the AR handshake, then hold R until accepted.
    always_ff @(posedge A_clk or negedge A_reset) begin
        if (!A_reset) begin
            rd_state_r <= R_IDLE;
            ar_ready_r <= 1'b0;
            r_valid_r  <= 1'b0;
            r_resp_r   <= 1'b0;
            r_data_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        r_data_r   <= rd_data_s;
                        r_resp_r   <= ~rd_hit_s;
                        r_valid_r  <= 1'b1;
                        ar_ready_r <= 1'b0;
                        rd_state_r <= R_DATA;
                    end else begin
                        ar_ready_r <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (bus.R_ready) begin
                        r_valid_r  <= 1'b0;
                        ar_ready_r <= 1'b1;
                        rd_state_r <= R_IDLE;
                    end
                end
                default: begin
                    rd_state_r <= R_IDLE;
                    ar_ready_r <= 1'b0;
                    r_valid_r  <= 1'b0;
                    r_resp_r   <= 1'b0;
                    r_data_r   <= {DATA_WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign bus.AW_ready = aw_ready_r;
    assign bus.W_ready  = w_ready_r;
    assign bus.B_valid  = b_valid_r;
    assign bus.B_resp   = b_resp_r;
    assign bus.AR_ready = ar_ready_r;
    assign bus.R_valid  = r_valid_r;
    assign bus.R_resp   = r_resp_r;
    assign bus.R_data   = r_data_r;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Testbench for axi_lite_reg_slave: directed scenarios followed by random
// reads/writes, all checked against an array model of the register file.
module tb_axi_lite_reg_slave;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int NR = 16;

    logic A_clk   = 1'b0;
    logic A_reset = 1'b0;

    axi_lite_reg_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_lite_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .A_clk   (A_clk),
        .A_reset (A_reset),
        .bus     (bus)
    );

    always #5 A_clk = ~A_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the register contents as software sees them.
    logic [7:0] model [NR];

    function automatic logic [7:0] exp_read(input logic [7:0] addr);
        if (int'(addr) < NR) return model[addr[3:0]];
        return 8'h00;
    endfunction

    function automatic logic exp_err(input logic [7:0] addr);
        return (int'(addr) >= NR);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive AW after aw_dly cycles and W after w_dly cycles; ends at the negedge
    // after the commit edge, with B_valid expected high.
    task automatic do_write(input logic [7:0] addr, input logic [7:0] data,
                            input int aw_dly, input int w_dly);
        bit   aw_done = 1'b0;
        bit   w_done  = 1'b0;
        logic aw_rdy;
        logic w_rdy;
        int   cyc = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            @(negedge A_clk);
            if (aw_done) chk("aw_ready_low_while_held", 32'(bus.AW_ready), 32'd0);
            if (w_done)  chk("w_ready_low_while_held", 32'(bus.W_ready), 32'd0);
            bus.AW_valid = (!aw_done && cyc >= aw_dly);
            bus.AW_addr  = addr;
            bus.W_valid  = (!w_done && cyc >= w_dly);
            bus.W_data   = data;
            aw_rdy = bus.AW_ready;
            w_rdy  = bus.W_ready;
            @(posedge A_clk);
            if (bus.AW_valid && aw_rdy) aw_done = 1'b1;
            if (bus.W_valid && w_rdy)   w_done  = 1'b1;
            cyc++;
        end
        @(negedge A_clk);
        bus.AW_valid = 1'b0;
        bus.W_valid  = 1'b0;
        chk("write_handshakes_done", 32'(aw_done && w_done), 32'd1);
        chk("b_valid_latency", 32'(bus.B_valid), 32'd1);
        chk("b_resp", 32'(bus.B_resp), 32'(exp_err(addr)));
        if (int'(addr) < NR) model[addr[3:0]] = data;
    endtask

    // Hold B_ready low for 'hold' cycles while poking the write inputs, then accept.
    task automatic b_accept(input int hold, input logic exp_resp);
        for (int i = 0; i < hold; i++) begin
            bus.B_ready  = 1'b0;
            bus.AW_valid = 1'b1;
            bus.AW_addr  = 8'($urandom);
            bus.W_valid  = 1'b1;
            bus.W_data   = 8'($urandom);
            @(posedge A_clk);
            @(negedge A_clk);
            chk("b_valid_held", 32'(bus.B_valid), 32'd1);
            chk("b_resp_held", 32'(bus.B_resp), 32'(exp_resp));
            chk("aw_ready_low_in_resp", 32'(bus.AW_ready), 32'd0);
            chk("w_ready_low_in_resp", 32'(bus.W_ready), 32'd0);
        end
        bus.AW_valid = 1'b0;
        bus.W_valid  = 1'b0;
        bus.B_ready  = 1'b1;
        @(posedge A_clk);
        @(negedge A_clk);
        bus.B_ready = 1'b0;
        chk("b_valid_cleared", 32'(bus.B_valid), 32'd0);
        chk("aw_ready_back", 32'(bus.AW_ready), 32'd1);
        chk("w_ready_back", 32'(bus.W_ready), 32'd1);
    endtask

    task automatic write_txn(input logic [7:0] addr, input logic [7:0] data,
                             input int aw_dly, input int w_dly, input int hold);
        do_write(addr, data, aw_dly, w_dly);
        b_accept(hold, exp_err(addr));
    endtask

    // AR handshake; ends at the negedge after it with R outputs expected valid.
    task automatic do_read(input logic [7:0] addr, input logic [7:0] exp_data);
        bit   done = 1'b0;
        logic rdy;
        int   cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge A_clk);
            bus.AR_valid = 1'b1;
            bus.AR_addr  = addr;
            rdy = bus.AR_ready;
            @(posedge A_clk);
            if (rdy) done = 1'b1;
            cyc++;
        end
        @(negedge A_clk);
        bus.AR_valid = 1'b0;
        chk("read_handshake_done", 32'(done), 32'd1);
        chk("r_valid_latency", 32'(bus.R_valid), 32'd1);
        chk("r_data", 32'(bus.R_data), 32'(exp_data));
        chk("r_resp", 32'(bus.R_resp), 32'(exp_err(addr)));
    endtask

    task automatic r_accept(input int hold, input logic [7:0] exp_data, input logic exp_resp);
        for (int i = 0; i < hold; i++) begin
            bus.R_ready  = 1'b0;
            bus.AR_valid = 1'b1;
            bus.AR_addr  = 8'($urandom);
            @(posedge A_clk);
            @(negedge A_clk);
            chk("r_valid_held", 32'(bus.R_valid), 32'd1);
            chk("r_data_held", 32'(bus.R_data), 32'(exp_data));
            chk("r_resp_held", 32'(bus.R_resp), 32'(exp_resp));
            chk("ar_ready_low_in_data", 32'(bus.AR_ready), 32'd0);
        end
        bus.AR_valid = 1'b0;
        bus.R_ready  = 1'b1;
        @(posedge A_clk);
        @(negedge A_clk);
        bus.R_ready = 1'b0;
        chk("r_valid_cleared", 32'(bus.R_valid), 32'd0);
        chk("ar_ready_back", 32'(bus.AR_ready), 32'd1);
    endtask

    task automatic read_txn(input logic [7:0] addr, input int hold);
        logic [7:0] e;
        e = exp_read(addr);
        do_read(addr, e);
        r_accept(hold, e, exp_err(addr));
    endtask

    // Write and read the same address on one edge; the read must see the old value.
    task automatic same_cycle_rw(input logic [7:0] addr, input logic [7:0] data);
        logic [7:0] old;
        old = exp_read(addr);
        @(negedge A_clk);
        chk("rw_aw_ready", 32'(bus.AW_ready), 32'd1);
        chk("rw_w_ready", 32'(bus.W_ready), 32'd1);
        chk("rw_ar_ready", 32'(bus.AR_ready), 32'd1);
        bus.AW_valid = 1'b1;
        bus.AW_addr  = addr;
        bus.W_valid  = 1'b1;
        bus.W_data   = data;
        bus.AR_valid = 1'b1;
        bus.AR_addr  = addr;
        @(posedge A_clk);
        @(negedge A_clk);
        bus.AW_valid = 1'b0;
        bus.W_valid  = 1'b0;
        bus.AR_valid = 1'b0;
        chk("rw_b_valid", 32'(bus.B_valid), 32'd1);
        chk("rw_r_valid", 32'(bus.R_valid), 32'd1);
        chk("rw_r_data_old", 32'(bus.R_data), 32'(old));
        if (int'(addr) < NR) model[addr[3:0]] = data;
        b_accept(0, exp_err(addr));
        r_accept(0, old, exp_err(addr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a;
        logic [7:0] d;

        for (int i = 0; i < NR; i++) model[i] = 8'h00;
        bus.AW_valid = 1'b0; bus.AW_addr = 8'h00;
        bus.W_valid  = 1'b0; bus.W_data  = 8'h00;
        bus.B_ready  = 1'b0;
        bus.AR_valid = 1'b0; bus.AR_addr = 8'h00;
        bus.R_ready  = 1'b0;

        // Reset state
        #12;
        chk("rst_b_valid", 32'(bus.B_valid), 32'd0);
        chk("rst_b_resp", 32'(bus.B_resp), 32'd0);
        chk("rst_r_valid", 32'(bus.R_valid), 32'd0);
        chk("rst_r_resp", 32'(bus.R_resp), 32'd0);
        chk("rst_r_data", 32'(bus.R_data), 32'd0);
        chk("rst_aw_ready", 32'(bus.AW_ready), 32'd0);
        chk("rst_w_ready", 32'(bus.W_ready), 32'd0);
        chk("rst_ar_ready", 32'(bus.AR_ready), 32'd0);
        @(negedge A_clk);
        A_reset = 1'b1;

        // 1: AW and W together, then read back
        write_txn(8'h03, 8'h5A, 0, 0, 0);
        read_txn(8'h03, 0);

        // 2: W two cycles before AW
        write_txn(8'h07, 8'hC3, 2, 0, 0);
        read_txn(8'h07, 0);
        // AW ahead of W as well
        write_txn(8'h0F, 8'h96, 0, 3, 0);
        read_txn(8'h0F, 0);

        // 3: out-of-range write and reads, boundary addresses
        write_txn(8'h20, 8'hEE, 0, 0, 0);
        read_txn(8'h20, 0);
        write_txn(8'h10, 8'hAB, 1, 0, 0);
        read_txn(8'h10, 0);
        read_txn(8'hFF, 0);
        for (int i = 0; i < NR; i++) read_txn(8'(i), 0);

        // 4: back-pressure on both response channels
        write_txn(8'h02, 8'h3C, 0, 0, 5);
        read_txn(8'h02, 4);

        // 5: same-edge write and read of register 5
        write_txn(8'h05, 8'h11, 0, 0, 0);
        same_cycle_rw(8'h05, 8'h22);
        read_txn(8'h05, 0);

        // Random traffic against the model
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(NR, 255));
            else                           a = 8'($urandom_range(0, NR - 1));
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 0)
                write_txn(a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                read_txn(a, $urandom_range(0, 2));
        end

        // 6: reset while a write response is pending
        do_write(8'h09, 8'h77, 0, 0);
        #2;
        A_reset = 1'b0;
        #1;
        chk("midrst_b_valid", 32'(bus.B_valid), 32'd0);
        chk("midrst_aw_ready", 32'(bus.AW_ready), 32'd0);
        chk("midrst_w_ready", 32'(bus.W_ready), 32'd0);
        chk("midrst_ar_ready", 32'(bus.AR_ready), 32'd0);
        for (int i = 0; i < NR; i++) model[i] = 8'h00;
        @(negedge A_clk);
        A_reset = 1'b1;
        repeat (2) @(negedge A_clk);
        chk("postrst_aw_ready", 32'(bus.AW_ready), 32'd1);
        chk("postrst_w_ready", 32'(bus.W_ready), 32'd1);
        chk("postrst_ar_ready", 32'(bus.AR_ready), 32'd1);
        chk("postrst_b_valid", 32'(bus.B_valid), 32'd0);
        for (int i = 0; i < NR; i++) read_txn(8'(i), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
